// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute-stage result path.
package ex_stage_pkg;

   localparam int XLEN = 64;

   // Branch condition encodings carried in funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // One buffered result heading to the memory stage
   typedef struct packed {
      logic [XLEN-1:0] data;
      logic [XLEN-1:0] store_data;
      logic [4:0]      rd;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
   } ex_entry_t;

   localparam int ENTRY_W = $bits(ex_entry_t);

   // Upstream picks SUB/SLT/SLTU so that the zero flag alone decides the branch:
   // SUB is zero on equality, SLT/SLTU are zero when "not less than".
   function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
      logic taken;
      case (funct3)
         F3_BEQ, F3_BGE, F3_BGEU: taken = zero;
         F3_BNE, F3_BLT, F3_BLTU: taken = ~zero;
         default:                 taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/ex_result_stage_fifo2.sv
// Two-entry elastic buffer with 1-bit head/tail pointers, a 2-bit occupancy
// count and a synchronous flush. Outputs come straight from the head entry.
module fifo2 #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         not_empty,
   output logic         not_full
);

   localparam logic [1:0] FULL_CNT = 2'(DEPTH);

   logic [W-1:0] mem_q [0:1];
   logic [W-1:0] mem_d [0:1];
   logic         head_q, head_d;
   logic         tail_q, tail_d;
   logic [1:0]   count_q, count_d;

   // Next-state for storage, pointers and count; flush overrides pointer/count motion
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         mem_d[tail_q] = wdata;
         tail_d        = ~tail_q;
      end
      if (pop) begin
         head_d = ~head_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (flush) begin
         head_d  = 1'b0;
         tail_d  = 1'b0;
         count_d = 2'd0;
      end
   end

   // State registers; reset also clears storage so outputs read zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q   <= '{default: '0};
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign rdata     = mem_q[head_q];
   assign not_empty = (count_q != 2'd0);
   assign not_full  = (count_q != FULL_CNT);

endmodule

// File: rtl/ex_result_stage.sv
// Execute-stage result stage: W-op sign extension, branch/jump resolution from
// the ALU zero flag, a 2-entry buffer toward memory and a one-cycle PC redirect.
module ex_result_stage
   import ex_stage_pkg::*;
#(
   parameter int N     = 64,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] alu_result,
   input  logic         alu_zero,
   input  logic         w_op,
   input  logic         is_branch,
   input  logic         is_link,
   input  logic [2:0]   br_funct3,
   input  logic [N-1:0] br_target,
   input  logic [N-1:0] pc_plus4,
   input  logic [N-1:0] store_data,
   input  logic [4:0]   rd,
   input  logic         reg_write,
   input  logic         mem_read,
   input  logic         mem_write,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic [N-1:0] out_store_data,
   output logic [4:0]   out_rd,
   output logic         out_reg_write,
   output logic         out_mem_read,
   output logic         out_mem_write,
   output logic         redirect_valid,
   output logic [N-1:0] redirect_pc
);

   logic         accept;
   logic         pop;
   logic         taken;
   ex_entry_t    new_entry;
   ex_entry_t    head_entry;
   logic         redirect_valid_q, redirect_valid_d;
   logic [N-1:0] redirect_pc_q, redirect_pc_d;

   // Flush kills this cycle's accept, which also suppresses its redirect
   assign accept = in_valid & in_ready & ~flush;
   assign pop    = out_valid & out_ready;

   // Build the entry to enqueue and the redirect next-state
   always_comb begin
      taken = is_branch & branch_taken(br_funct3, alu_zero);

      new_entry            = '0;
      new_entry.store_data = store_data;
      new_entry.rd         = rd;
      if (is_link) begin
         new_entry.data = pc_plus4;
      end else if (w_op) begin
         new_entry.data = {{(N-32){alu_result[31]}}, alu_result[31:0]};
      end else begin
         new_entry.data = alu_result;
      end
      // Branches keep their slot for ordering but must not write anything
      new_entry.reg_write = reg_write & ~is_branch;
      new_entry.mem_read  = mem_read  & ~is_branch;
      new_entry.mem_write = mem_write & ~is_branch;

      redirect_valid_d = accept & (taken | is_link);
      redirect_pc_d    = redirect_valid_d ? br_target : redirect_pc_q;
   end

   // Redirect pulse register; the target holds between pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   fifo2 #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (accept),
      .pop       (pop),
      .wdata     (new_entry),
      .rdata     (head_entry),
      .not_empty (out_valid),
      .not_full  (in_ready)
   );

   assign out_data       = head_entry.data;
   assign out_store_data = head_entry.store_data;
   assign out_rd         = head_entry.rd;
   assign out_reg_write  = head_entry.reg_write;
   assign out_mem_read   = head_entry.mem_read;
   assign out_mem_write  = head_entry.mem_write;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Bench for ex_result_stage: directed vector table, hand-written multi-cycle
// corner cases, then randomized traffic against a queue-based reference model.
module tb_ex_result_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush, in_valid, in_ready;
   logic [63:0] alu_result, br_target, pc_plus4, store_data;
   logic        alu_zero, w_op, is_branch, is_link;
   logic [2:0]  br_funct3;
   logic [4:0]  rd;
   logic        reg_write, mem_read, mem_write;
   logic        out_valid, out_ready;
   logic [63:0] out_data, out_store_data;
   logic [4:0]  out_rd;
   logic        out_reg_write, out_mem_read, out_mem_write;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   int total = 0;
   int bad   = 0;
   logic [63:0] last_rpc = 64'h0;

   always #5 clk = ~clk;

   ex_result_stage dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alu_result(alu_result), .alu_zero(alu_zero), .w_op(w_op), .is_branch(is_branch),
      .is_link(is_link), .br_funct3(br_funct3), .br_target(br_target), .pc_plus4(pc_plus4),
      .store_data(store_data), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
      .mem_write(mem_write), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_store_data(out_store_data), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      flush = 0; in_valid = 0; out_ready = 0;
      alu_result = 0; alu_zero = 0; w_op = 0; is_branch = 0; is_link = 0;
      br_funct3 = 0; br_target = 0; pc_plus4 = 0; store_data = 0; rd = 0;
      reg_write = 0; mem_read = 0; mem_write = 0;
   endtask

   // Drive a plain register-writing ALU op carrying value v into rd r
   task automatic drive_plain(input logic [63:0] v, input logic [4:0] r);
      in_valid = 1; alu_result = v; rd = r; reg_write = 1;
      w_op = 0; is_branch = 0; is_link = 0; mem_read = 0; mem_write = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      idle_inputs();
      @(negedge clk);
      reset = 0;
      last_rpc = 0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      string       name;
      logic [63:0] alu;
      logic        zero, w, br, link;
      logic [2:0]  f3;
      logic [63:0] tgt, pc4, sd;
      logic [4:0]  rdv;
      logic        rw, mr, mw;
      logic [63:0] e_data;
      logic        e_rw, e_mr, e_mw, e_redir;
   } vec_t;

   vec_t vt [14];

   task automatic apply_vec(input vec_t v);
      @(negedge clk);
      in_valid = 1; out_ready = 0; flush = 0;
      alu_result = v.alu; alu_zero = v.zero; w_op = v.w; is_branch = v.br;
      is_link = v.link; br_funct3 = v.f3; br_target = v.tgt; pc_plus4 = v.pc4;
      store_data = v.sd; rd = v.rdv; reg_write = v.rw; mem_read = v.mr; mem_write = v.mw;
      @(negedge clk);
      in_valid = 0;
      if (v.e_redir) last_rpc = v.tgt;
      chk({v.name, ".out_valid"}, out_valid, 1);
      chk({v.name, ".data"}, out_data, v.e_data);
      chk({v.name, ".store_data"}, out_store_data, v.sd);
      chk({v.name, ".rd"}, out_rd, v.rdv);
      chk({v.name, ".reg_write"}, out_reg_write, v.e_rw);
      chk({v.name, ".mem_read"}, out_mem_read, v.e_mr);
      chk({v.name, ".mem_write"}, out_mem_write, v.e_mw);
      chk({v.name, ".redirect_valid"}, redirect_valid, v.e_redir);
      chk({v.name, ".redirect_pc"}, redirect_pc, last_rpc);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk({v.name, ".pulse_end"}, redirect_valid, 0);
      chk({v.name, ".drained"}, out_valid, 0);
   endtask

   // ---------------- reference model for random phase ----------------
   typedef struct packed {
      logic [63:0] d;
      logic [63:0] sd;
      logic [4:0]  r;
      logic        rw, mr, mw;
   } exp_t;

   exp_t        mq [$];
   logic        m_rv;
   logic [63:0] m_rpc;

   // Branch decision from the meaning of each compare: SUB gives zero on equal,
   // SLT/SLTU give zero when the "less than" test fails.
   function automatic logic ref_taken(input logic [2:0] f3, input logic zero);
      logic equal, less;
      equal = zero;
      less  = ~zero;
      case (f3)
         3'd0: return equal;          // BEQ  (SUB)
         3'd1: return ~equal;         // BNE  (SUB)
         3'd4: return less;           // BLT  (SLT)
         3'd5: return ~less;          // BGE  (SLT)
         3'd6: return less;           // BLTU (SLTU)
         3'd7: return ~less;          // BGEU (SLTU)
         default: return 1'b0;
      endcase
   endfunction

   task automatic random_phase(input int cycles);
      int   kind;
      logic acc, pp, tk;
      exp_t e;
      mq.delete();
      m_rv = 0; m_rpc = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         chk("rnd.out_valid", out_valid, mq.size() != 0);
         chk("rnd.in_ready", in_ready, mq.size() < 2);
         chk("rnd.redirect_valid", redirect_valid, m_rv);
         chk("rnd.redirect_pc", redirect_pc, m_rpc);
         if (mq.size() != 0) begin
            chk("rnd.data", out_data, mq[0].d);
            chk("rnd.store_data", out_store_data, mq[0].sd);
            chk("rnd.rd", out_rd, mq[0].r);
            chk("rnd.flags", {out_reg_write, out_mem_read, out_mem_write},
                {mq[0].rw, mq[0].mr, mq[0].mw});
         end
         in_valid   = $urandom_range(0, 3) != 0;
         out_ready  = $urandom_range(0, 2) != 0;
         flush      = $urandom_range(0, 15) == 0;
         kind       = $urandom_range(0, 3);
         alu_result = {$urandom, $urandom};
         alu_zero   = $urandom_range(0, 1);
         br_funct3  = 3'($urandom_range(0, 7));
         br_target  = {$urandom, $urandom};
         pc_plus4   = {$urandom, $urandom};
         store_data = {$urandom, $urandom};
         rd         = 5'($urandom);
         reg_write  = $urandom_range(0, 1);
         mem_read   = $urandom_range(0, 1);
         mem_write  = $urandom_range(0, 1);
         is_branch  = (kind == 2);
         is_link    = (kind == 3);
         w_op       = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
         // model next state
         acc = in_valid && mq.size() < 2 && !flush;
         pp  = mq.size() != 0 && out_ready;
         tk  = is_branch && ref_taken(br_funct3, alu_zero);
         if (is_link)   e.d = pc_plus4;
         else if (w_op) e.d = 64'(signed'(alu_result[31:0]));
         else           e.d = alu_result;
         e.sd = store_data;
         e.r  = rd;
         e.rw = reg_write && !is_branch;
         e.mr = mem_read && !is_branch;
         e.mw = mem_write && !is_branch;
         @(posedge clk);
         if (pp)    void'(mq.pop_front());
         if (flush) mq.delete();
         if (acc)   mq.push_back(e);
         m_rv = acc && (tk || is_link);
         if (m_rv) m_rpc = br_target;
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vt[0]  = '{"addw", 64'h0000_0000_8000_0000, 0, 1, 0, 0, 3'd0, 64'h0, 64'h0, 64'h11, 5'd5, 1, 0, 0,
                 64'hFFFF_FFFF_8000_0000, 1, 0, 0, 0};
      vt[1]  = '{"bne_taken", 64'h5, 0, 0, 1, 0, 3'b001, 64'h1000, 64'h0, 64'h0, 5'd7, 1, 1, 1,
                 64'h5, 0, 0, 0, 1};
      vt[2]  = '{"bge_not", 64'h1, 0, 0, 1, 0, 3'b101, 64'h1000, 64'h0, 64'h0, 5'd0, 0, 0, 0,
                 64'h1, 0, 0, 0, 0};
      vt[3]  = '{"f3_010", 64'h0, 1, 0, 1, 0, 3'b010, 64'h1000, 64'h0, 64'h0, 5'd0, 0, 0, 0,
                 64'h0, 0, 0, 0, 0};
      vt[4]  = '{"jal", 64'h1234, 1, 0, 0, 1, 3'd0, 64'h3000, 64'h2004, 64'h0, 5'd1, 1, 0, 0,
                 64'h2004, 1, 0, 0, 1};
      vt[5]  = '{"load", 64'h1234_5678_9abc_def0, 0, 0, 0, 0, 3'd0, 64'h0, 64'h0, 64'h0, 5'd10, 1, 1, 0,
                 64'h1234_5678_9abc_def0, 1, 1, 0, 0};
      vt[6]  = '{"store", 64'h100, 0, 0, 0, 0, 3'd0, 64'h0, 64'h0, 64'hdead_beef_cafe_f00d, 5'd0, 0, 0, 1,
                 64'h100, 0, 0, 1, 0};
      vt[7]  = '{"beq_taken", 64'h0, 1, 0, 1, 0, 3'b000, 64'h4000, 64'h0, 64'h0, 5'd0, 0, 0, 0,
                 64'h0, 0, 0, 0, 1};
      vt[8]  = '{"bltu_taken", 64'h1, 0, 0, 1, 0, 3'b110, 64'h5000, 64'h0, 64'h0, 5'd0, 0, 0, 0,
                 64'h1, 0, 0, 0, 1};
      vt[9]  = '{"bgeu_taken", 64'h0, 1, 0, 1, 0, 3'b111, 64'h6000, 64'h0, 64'h0, 5'd0, 0, 0, 0,
                 64'h0, 0, 0, 0, 1};
      vt[10] = '{"blt_not", 64'h0, 1, 0, 1, 0, 3'b100, 64'h7000, 64'h0, 64'h0, 5'd0, 0, 0, 0,
                 64'h0, 0, 0, 0, 0};
      vt[11] = '{"subw_pos", 64'hFFFF_FFFF_7FFF_FFFF, 0, 1, 0, 0, 3'd0, 64'h0, 64'h0, 64'h0, 5'd3, 1, 0, 0,
                 64'h0000_0000_7FFF_FFFF, 1, 0, 0, 0};
      vt[12] = '{"jalr_w", 64'h8000_0000, 0, 1, 0, 1, 3'd0, 64'h9000, 64'h88, 64'h0, 5'd1, 1, 0, 0,
                 64'h88, 1, 0, 0, 1};
      vt[13] = '{"bne_not", 64'h0, 1, 0, 1, 0, 3'b001, 64'hA000, 64'h0, 64'h0, 5'd0, 0, 0, 0,
                 64'h0, 0, 0, 0, 0};

      idle_inputs();
      #1 reset = 1;
      @(negedge clk);
      @(negedge clk);
      // reset state
      chk("rst.out_valid", out_valid, 0);
      chk("rst.in_ready", in_ready, 1);
      chk("rst.redirect_valid", redirect_valid, 0);
      chk("rst.redirect_pc", redirect_pc, 0);
      chk("rst.out_data", out_data, 0);
      chk("rst.out_store_data", out_store_data, 0);
      chk("rst.out_rd", out_rd, 0);
      chk("rst.enables", {out_reg_write, out_mem_read, out_mem_write}, 0);
      reset = 0;
      @(negedge clk);
      chk("idle.out_valid", out_valid, 0);
      chk("idle.in_ready", in_ready, 1);

      for (int i = 0; i < 14; i++) apply_vec(vt[i]);

      // back-pressure: three back-to-back valids, only two fit
      @(negedge clk);
      drive_plain(64'hA1, 5'd1);
      @(negedge clk);
      chk("bp.in_ready_1", in_ready, 1);
      chk("bp.out_valid_1", out_valid, 1);
      drive_plain(64'hA2, 5'd2);
      @(negedge clk);
      chk("bp.in_ready_full", in_ready, 0);
      drive_plain(64'hA3, 5'd3);
      @(negedge clk);
      chk("bp.in_ready_held", in_ready, 0);
      chk("bp.head_first", out_data, 64'hA1);
      in_valid = 0; out_ready = 1;
      @(negedge clk);
      chk("bp.in_ready_after_pop", in_ready, 1);
      chk("bp.head_second", out_data, 64'hA2);
      chk("bp.rd_second", out_rd, 2);
      @(negedge clk);
      chk("bp.drained", out_valid, 0);
      out_ready = 0;

      // flush with a full buffer while a taken branch is offered
      drive_plain(64'hB1, 5'd4);
      @(negedge clk);
      drive_plain(64'hB2, 5'd5);
      @(negedge clk);
      flush = 1; in_valid = 1; is_branch = 1; br_funct3 = 3'b000; alu_zero = 1;
      br_target = 64'hABC0; reg_write = 0;
      @(negedge clk);
      idle_inputs();
      chk("fl2.out_valid", out_valid, 0);
      chk("fl2.in_ready", in_ready, 1);
      chk("fl2.redirect_valid", redirect_valid, 0);

      // flush with one entry while an otherwise-accepted taken branch arrives
      drive_plain(64'hC1, 5'd6);
      @(negedge clk);
      chk("fl1.pre_in_ready", in_ready, 1);
      flush = 1; in_valid = 1; is_branch = 1; br_funct3 = 3'b000; alu_zero = 1;
      br_target = 64'hABC0; reg_write = 0;
      @(negedge clk);
      idle_inputs();
      chk("fl1.out_valid", out_valid, 0);
      chk("fl1.in_ready", in_ready, 1);
      chk("fl1.redirect_valid", redirect_valid, 0);
      chk("fl1.redirect_pc", redirect_pc, last_rpc);
      @(negedge clk);
      chk("fl1.still_empty", out_valid, 0);

      // pop and flush in the same cycle: head seen once, nothing after
      drive_plain(64'hD1, 5'd8);
      @(negedge clk);
      drive_plain(64'hD2, 5'd9);
      @(negedge clk);
      in_valid = 0;
      chk("popfl.head", out_data, 64'hD1);
      chk("popfl.valid", out_valid, 1);
      out_ready = 1; flush = 1;
      @(negedge clk);
      idle_inputs();
      chk("popfl.after_valid", out_valid, 0);
      chk("popfl.after_in_ready", in_ready, 1);

      // asynchronous reset mid-stream with two entries and a pending pulse
      drive_plain(64'hE1, 5'd10);
      @(negedge clk);
      in_valid = 1; is_link = 1; pc_plus4 = 64'h44; br_target = 64'h7700;
      @(posedge clk);
      #2;
      idle_inputs();
      reset = 1;
      #1;
      chk("amr.out_valid", out_valid, 0);
      chk("amr.in_ready", in_ready, 1);
      chk("amr.redirect_valid", redirect_valid, 0);
      chk("amr.redirect_pc", redirect_pc, 0);
      chk("amr.out_data", out_data, 0);
      @(negedge clk);
      reset = 0;
      last_rpc = 0;

      do_reset();
      random_phase(1500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_result_stage.md
# ex_result_stage

Execute-stage result stage sitting directly downstream of the 64-bit ALU. Each cycle it accepts one ALU result, its flags and the instruction's sideband. It applies RV64 word-op sign extension and resolves conditional branches and jumps from the ALU `zero` flag. Results are buffered in a 2-entry elastic buffer toward the memory stage, and a one-cycle PC redirect is issued for taken control transfers.

## Interface
- `N`, 64: datapath width.
- `DEPTH`, 2: buffer entries; fixed at 2, other values unsupported.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: discard all buffered entries and suppress the redirect from this cycle's accept.
- `in_valid` in 1: upstream presents an instruction.
- `in_ready` out 1: stage can accept; registered, equals count<2.
- `alu_result` in N: ALU result.
- `alu_zero` in 1: ALU zero flag.
- `w_op` in 1: RV64 W-form instruction.
- `is_branch` in 1: conditional branch.
- `is_link` in 1: JAL/JALR.
- `br_funct3` in 3: branch condition.
- `br_target` in N: precomputed target PC.
- `pc_plus4` in N: link value.
- `store_data` in N: rs2 for stores.
- `rd` in 5: destination register.
- `reg_write` in 1: writes rd.
- `mem_read` in 1: load.
- `mem_write` in 1: store.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: memory stage consumes.
- `out_data` out N: write-back or address value.
- `out_store_data` out N: store data.
- `out_rd` out 5: destination register.
- `out_reg_write` out 1: write enable.
- `out_mem_read` out 1: load.
- `out_mem_write` out 1: store.
- `redirect_valid` out 1: one-cycle pulse.
- `redirect_pc` out N: target PC for the redirect.

## Operation
- Accept = `in_valid & in_ready & ~flush`. Pop = `out_valid & out_ready`.
- Data selection:
  - `is_link`: data = `pc_plus4`.
  - `w_op`: data = `{{32{alu_result[31]}}, alu_result[31:0]}`.
  - Otherwise: data = `alu_result`.
- Branch taken, by `br_funct3`:
  - BEQ 000 and BGE 101: `alu_zero`.
  - BNE 001, BLT 100 and BLTU 110: `~alu_zero`. Upstream drives SUB for BEQ/BNE, SLT for BLT/BGE and SLTU for BLTU/BGEU.
  - BGEU 111: `alu_zero`.
  - 010 and 011: not taken.
- Branches are enqueued with `reg_write=0`, `mem_read=0` and `mem_write=0`, and still occupy an entry to preserve order.
- Redirect:
  - Taken branch or `is_link` on accept: `redirect_valid=1` and `redirect_pc=br_target` next cycle, for one cycle.
  - Otherwise `redirect_valid=0`; `redirect_pc` holds its last value.
- Buffer: FIFO with head/tail pointers (1 bit each, wrap 1→0) and a 2-bit count.
  - Push at tail, pop from head. Outputs are driven from the head entry.
  - Push and pop in the same cycle leave count unchanged.
- `in_ready=0` at count 2, so there is no push into a full buffer.
- Pop at count 0 is impossible because `out_valid=0`.
- Flush:
  - Next cycle count=0, head=tail=0, `out_valid=0`, `in_ready=1`.
  - A pop in the flush cycle completes normally downstream.
  - An accept in the flush cycle is dropped and produces no redirect.
  - A pending redirect pulse already registered is not retracted.

## Timing
- Reset (asynchronous, immediate):
  - count=0, pointers=0.
  - `out_valid=0`, `in_ready=1`.
  - `redirect_valid=0`, `redirect_pc=0`.
  - `out_data`, `out_store_data`, `out_rd` and all `out_*` enables = 0; entry storage is cleared.
- Reset mid-operation discards all entries with no pulse.
- Latency: accept at edge k → entry visible on `out_*` and redirect pulse at k+1.
- Throughput: 1 instruction/cycle while `out_ready=1`.
- Back-pressure: with `out_ready=0`, two accepts fill the buffer. `in_ready` drops the cycle after the second accept, and rises the cycle after the first pop.
- All outputs are registered or driven from registered state. There is no combinational path from `out_ready` to `in_ready`, and none from inputs to outputs.

## Structure
- Package `ex_stage_pkg`:
  - Branch funct3 constants: `F3_BEQ`, `F3_BNE`, `F3_BLT`, `F3_BGE`, `F3_BLTU`, `F3_BGEU`.
  - Struct typedef `ex_entry_t` with fields data, store_data, rd, reg_write, mem_read, mem_write.
- Sub-module `fifo2` (parameterised on entry type/width) holds the storage, pointers and count, plus flush. Sign extension, branch resolution and the redirect register live in the top.

## Test plan
- Reset then idle:
  - All outputs 0 and `in_ready=1`.
  - Assert `reset` mid-stream with 2 entries held → `out_valid=0` immediately.
- ADDW with `alu_result=0x0000_0000_8000_0000`, `w_op=1`, rd=5 → next cycle `out_data=0xFFFF_FFFF_8000_0000`, `out_rd=5`, `out_reg_write=1`.
- Branches with target 0x1000:
  - BNE with `alu_zero=0` → `redirect_valid` pulse of 1 cycle, `redirect_pc=0x1000`, entry has `reg_write=0`.
  - BGE with `alu_zero=0` → no pulse.
  - funct3=010 → no pulse.
- JAL with `pc_plus4=0x2004` and target 0x3000 → `out_data=0x2004` and redirect to 0x3000.
- Back-pressure:
  - `out_ready=0`, 3 back-to-back valids → only 2 accepted and `in_ready=0`.
  - Then `out_ready=1` → entries drain in order, `in_ready=1` after the first pop.
- Flush:
  - `flush` with 2 entries plus a simultaneous accepted taken branch → next cycle count=0, no redirect, `in_ready=1`.
  - Simultaneous pop + flush → popped entry observed once.
